mem_arbiter: RTL

Two-requester arbiter that shares the single unified memory (instruction/data/LED-mapped) between the RISC-V core (port 0) and a second bus master such as a program loader or debug/DMA engine (port 1). Sits between the requesters and the memory's `write_mem`/`funct3`/`write_address`/`write_data`/`read_address`/`read_data` pins. Issues at most one memory access per cycle, tags read data back to the issuing port, and supports bounded bus locking for multi-access sequences.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// master: the requesters plus the memory model (drive requests and mem_rd).
// slave: the arbiter itself.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32
);
  logic          req0, req1;
  logic          we0, we1;
  logic          lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic [2:0]    funct3_0, funct3_1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [31:0]   rdata;
  logic          mem_wen;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_wa, mem_ra;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1,
           wdata0, wdata1, funct3_0, funct3_1, mem_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_wen, mem_funct3, mem_wa, mem_ra, mem_wd
  );

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1,
           wdata0, wdata1, funct3_0, funct3_1, mem_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_wen, mem_funct3, mem_wa, mem_ra, mem_wd
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the unified memory. One access per cycle,
// read data tagged back to the issuing port, bounded bus locking.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration in idle;
// otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int unsigned MAX_LOCK = 16,
  parameter int unsigned AW       = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LockLast = CW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          force_q, force_d;          // previous cycle ended a lock by force
  logic          force_own_q, force_own_d;  // port whose lock was forced off
  logic          rpend_q, rpend_d;
  logic          rtag_q, rtag_d;
  logic [AW-1:0] addr_q, addr_d;            // last granted address, held while idle
  logic [31:0]   wd_q, wd_d;
  logic [2:0]    f3_q, f3_d;
`ifdef MEM_ARB_RR_EN
  logic          prio_q, prio_d;
`endif

  logic          gnt0, gnt1, gnt_any, sel;
  logic          sel_we, sel_lock;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wd;
  logic [2:0]    sel_f3;

  // Grant decode: combinational from requests, state and priority.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      StIdle: begin
        if (force_q && (force_own_q ? bus.req0 : bus.req1)) begin
          // The port starved by a forced release wins outright.
          gnt0 = force_own_q;
          gnt1 = ~force_own_q;
        end else begin
`ifdef MEM_ARB_RR_EN
          if (bus.req0 && bus.req1) begin
            gnt0 = ~prio_q;
            gnt1 = prio_q;
          end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
          end
`else
          gnt0 = bus.req0;
          gnt1 = bus.req1 & ~bus.req0;
`endif
        end
      end
      StOwn0:  gnt0 = bus.req0;
      StOwn1:  gnt1 = bus.req1;
      default: ;
    endcase
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // Granted-port request mux.
  always_comb begin
    gnt_any  = gnt0 | gnt1;
    sel      = gnt1;
    sel_we   = sel ? bus.we1      : bus.we0;
    sel_lock = sel ? bus.lock1    : bus.lock0;
    sel_addr = sel ? bus.addr1    : bus.addr0;
    sel_wd   = sel ? bus.wdata1   : bus.wdata0;
    sel_f3   = sel ? bus.funct3_1 : bus.funct3_0;
  end

  // Ownership, lock counter and priority next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    force_d     = 1'b0;
    force_own_d = force_own_q;
`ifdef MEM_ARB_RR_EN
    prio_d      = prio_q;
`endif
    case (state_q)
      StIdle: begin
        if (gnt_any && sel_lock) begin
          state_d = sel ? StOwn1 : StOwn0;
          cnt_d   = CW'(1);
        end else if (gnt_any) begin
`ifdef MEM_ARB_RR_EN
          prio_d = ~sel;
`endif
        end
      end
      StOwn0, StOwn1: begin
        if (!gnt_any) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (!sel_lock) begin
          state_d = StIdle;
          cnt_d   = '0;
`ifdef MEM_ARB_RR_EN
          prio_d  = ~sel;
`endif
        end else if (cnt_q >= LockLast) begin
          state_d     = StIdle;
          cnt_d       = '0;
          force_d     = 1'b1;
          force_own_d = sel;
`ifdef MEM_ARB_RR_EN
          prio_d      = ~sel;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read tracking and held memory-side values.
  always_comb begin
    rpend_d = gnt_any & ~sel_we;
    rtag_d  = gnt_any ? sel : rtag_q;
    addr_d  = gnt_any ? sel_addr : addr_q;
    wd_d    = gnt_any ? sel_wd : wd_q;
    f3_d    = gnt_any ? sel_f3 : f3_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      force_q     <= 1'b0;
      force_own_q <= 1'b0;
      rpend_q     <= 1'b0;
      rtag_q      <= 1'b0;
      addr_q      <= '0;
      wd_q        <= '0;
      f3_q        <= '0;
`ifdef MEM_ARB_RR_EN
      prio_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      force_q     <= force_d;
      force_own_q <= force_own_d;
      rpend_q     <= rpend_d;
      rtag_q      <= rtag_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      f3_q        <= f3_d;
`ifdef MEM_ARB_RR_EN
      prio_q      <= prio_d;
`endif
    end
  end

  // Output drive; idle cycles hold the last granted address/data.
  always_comb begin
    bus.gnt0       = gnt0;
    bus.gnt1       = gnt1;
    bus.mem_wen    = gnt_any & sel_we;
    bus.mem_ra     = addr_d;
    bus.mem_wa     = addr_d;
    bus.mem_wd     = wd_d;
    bus.mem_funct3 = f3_d;
    bus.rvalid0    = rpend_q & ~rtag_q;
    bus.rvalid1    = rpend_q & rtag_q;
    bus.rdata      = rpend_q ? bus.mem_rd : 32'h0;
  end

endmodule
